subbytes_folded: RTL and testbench
==================================

# subbytes_folded

Folded, mode-selectable SubBytes engine: applies the AES S-box (forward) or inverse S-box to an N_BYTES-byte state using only N_SBOX substitution lanes, iterating over the state in N_BYTES/N_SBOX passes. Successor to the fully parallel 16-lane SubBytes block, for area-constrained datapaths (key expansion, low-rate cipher cores). It adds a ready/valid input handshake, per-request encrypt/decrypt mode, and optional output registering.

## Interface
- NB_BYTE, 8, bits per byte; any other value is an elaboration error.
- N_BYTES, 16, bytes per state.
- N_SBOX, 4, substitution lanes instantiated.
  - N_BYTES % N_SBOX != 0 is an elaboration error.
  - P = N_BYTES/N_SBOX passes.
- CREATE_OUTPUT_REG, 1, when 1 adds one register stage on o_state/o_valid.
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_state  in  N_BYTES*NB_BYTE  input state; byte k = bits [k*NB_BYTE +: NB_BYTE].
- i_valid  in  1  request strobe; accepted when i_valid & o_ready at a rising edge.
- i_inverse  in  1  mode, sampled with the request: 0 = SubBytes, 1 = InvSubBytes.
- o_ready  out  1  engine idle, can accept a request this cycle.
- o_state  out  N_BYTES*NB_BYTE  substituted state; valid only while o_valid = 1.
- o_valid  out  1  one-cycle pulse marking o_state valid; no backpressure.

## Operation
- FSM states:
  - IDLE: o_ready = 1.
    - On accept: capture i_state into the input register, latch i_inverse, clear the pass counter cnt, go to RUN.
  - RUN: o_ready = 0.
    - Each cycle, the N_SBOX lanes substitute input bytes cnt*N_SBOX .. cnt*N_SBOX+N_SBOX-1.
    - The results are written into the same byte positions of the result register.
    - cnt increments each cycle.
    - When cnt == P-1: write the last slice, raise the internal done pulse, return to IDLE.
- Lanes are combinational. Each lane holds one forward and one inverse S-box, selected by the latched mode.
- cnt is ceil(log2(P)) bits, minimum 1. It never wraps past P-1.
- P = 1 (N_SBOX == N_BYTES): RUN lasts exactly one cycle.
- i_valid while o_ready = 0 is ignored: request dropped, no state change. Upstream must honour o_ready.
- Changes to i_state/i_inverse after the accept edge have no effect on the running operation.
- The result register is not cleared between operations.
  - With CREATE_OUTPUT_REG = 0, o_state shows partially updated data during RUN.
  - Consumers sample o_state only on o_valid.
- With CREATE_OUTPUT_REG = 1, o_state is loaded from the result register only on the done pulse, so it holds the last result stable until the next completion.

## Timing
- Reset (i_reset high at an edge):
  - State becomes IDLE, cnt = 0, result/input/output registers = 0, o_valid = 0.
  - o_ready = 0 while i_reset is high; o_ready = 1 the cycle after reset deasserts.
- Reset during RUN aborts the operation: no o_valid is ever produced for it.
- Latency, request accepted at edge E0:
  - Slices are written at edges E1..EP.
  - CREATE_OUTPUT_REG = 0: o_valid is high for the cycle following EP.
  - CREATE_OUTPUT_REG = 1: o_valid is high for the cycle following E(P+1).
- o_ready returns high in the cycle following EP.
- A new request accepted at E(P+1) overlaps the registered output of the previous one; this is legal.
- Throughput: one state per P+1 cycles. Back-to-back requests are accepted every P+1 edges.
- o_valid is never high on two consecutive cycles, except when P = 1 with back-to-back requests (period 2 cycles, still non-consecutive).

## Test plan
- Reset/idle:
  - Hold i_reset for 3 cycles with i_valid = 1.
  - Required: o_valid = 0 and o_ready = 0 throughout, o_state = 0.
  - o_ready = 1 the first cycle after release; no spurious o_valid.
- Forward, default params:
  - Request i_state = 0 (all bytes 0x00), i_inverse = 0.
  - Required: after 5 cycles (6 with output reg), o_valid pulses once with every byte = 0x63.
  - Byte 0 = 0x53, byte 1 = 0x01, all others 0x00 -> byte 0 = 0xED, byte 1 = 0x7C, others 0x63.
- Inverse round trip:
  - Feed the result of the previous vector back with i_inverse = 1.
  - Required: the original state (0x53, 0x01, 0x00...) is recovered exactly.
  - Inverse of all-0x63 -> all 0x00.
- Handshake/drop:
  - Assert i_valid continuously with changing i_state.
  - Required: accepts occur only at edges where o_ready = 1, every P+1 = 5 cycles.
  - Intermediate requests are dropped; outputs match only the accepted states.
  - Mode and data changes after accept do not alter the result.
- Reset mid-RUN:
  - Assert i_reset at pass 2 of 4.
  - Required: no o_valid for the aborted request; the next request completes correctly with normal latency.
- Parameter sweep:
  - N_SBOX ∈ {1, 2, 16}, CREATE_OUTPUT_REG ∈ {0, 1}, random states vs. a reference model.
  - Required: bit-exact results, latency P+1+CREATE_OUTPUT_REG.
  - P = 1: o_ready/o_valid periodicity of 2 cycles.

Source files
------------

// File: rtl/subbytes_folded.sv
// Folded AES SubBytes/InvSubBytes engine: N_SBOX lanes iterate over an N_BYTES
// state in N_BYTES/N_SBOX passes behind a ready/valid request port.
module subbytes_folded #(
  parameter int NB_BYTE           = 8,
  parameter int N_BYTES           = 16,
  parameter int N_SBOX            = 4,
  parameter int CREATE_OUTPUT_REG = 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [N_BYTES*NB_BYTE-1:0] i_state,
  input  logic                       i_valid,
  input  logic                       i_inverse,
  output logic                       o_ready,
  output logic [N_BYTES*NB_BYTE-1:0] o_state,
  output logic                       o_valid
);

  localparam int DW = N_BYTES * NB_BYTE;
  localparam int SW = N_SBOX * NB_BYTE;
  localparam int P  = N_BYTES / N_SBOX;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  if (NB_BYTE != 8) begin : g_bad_byte
    $error("subbytes_folded: NB_BYTE must be 8");
  end
  if ((N_BYTES % N_SBOX) != 0) begin : g_bad_fold
    $error("subbytes_folded: N_BYTES must be a multiple of N_SBOX");
  end

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic            r_inv;
  logic [DW-1:0]   r_in;
  logic [DW-1:0]   r_res;
  logic            r_done;
  logic            w_accept;
  logic            w_last;
  logic [SW-1:0]   w_slice_in;
  logic [SW-1:0]   w_slice_out;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    o_ready      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        o_ready = !i_reset;
        if (i_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_last = (r_cnt == CW'(P - 1));
        if (w_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_slice_in = '0;
    for (int unsigned s = 0; s < P; s++) begin
      if (r_cnt == CW'(s)) w_slice_in = r_in[s*SW +: SW];
    end
  end

  for (genvar l = 0; l < N_SBOX; l++) begin : g_lane
    logic [NB_BYTE-1:0] w_x;
    assign w_x = w_slice_in[l*NB_BYTE +: NB_BYTE];
    assign w_slice_out[l*NB_BYTE +: NB_BYTE] = r_inv ? inv_sbox(w_x) : fwd_sbox(w_x);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
      r_in    <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_last;
      if (w_accept) begin
        r_in  <= i_state;
        r_inv <= i_inverse;
        r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        for (int unsigned s = 0; s < P; s++) begin
          if (r_cnt == CW'(s)) r_res[s*SW +: SW] <= w_slice_out;
        end
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
    end
  end

  // r_done trails the last slice write, so the registered output samples a complete result.
  if (CREATE_OUTPUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] r_out;
    logic          r_out_valid;
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_out       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_done;
        if (r_done) r_out <= r_res;
      end
    end
    assign o_state = r_out;
    assign o_valid = r_out_valid;
  end else begin : g_out_comb
    assign o_state = r_res;
    assign o_valid = r_done;
  end

endmodule

// File: tb/tb_subbytes_folded.sv
// Directed bench for subbytes_folded across several lane counts and output-register settings.
module tb_subbytes_folded;

  localparam int ND   = 8;
  localparam int LOGN = 64;
  localparam int SB [ND] = '{4, 4, 1, 1, 2, 2, 16, 16};
  localparam int CR [ND] = '{1, 0, 1, 0, 1, 0, 1, 0};

  logic            clk = 1'b0;
  logic            rst;
  logic            vld;
  logic            inv;
  logic [127:0]    st;
  logic [ND-1:0]   w_rdy;
  logic [ND-1:0]   w_ov;
  logic [127:0]    w_st [ND];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [127:0] vlog [ND][LOGN];
  int           vcyc [ND][LOGN];
  int           vcnt [ND];
  int           consec [ND];
  logic [ND-1:0] prev_ov = '0;

  logic [7:0] fsb [256];
  logic [7:0] isb [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    subbytes_folded #(
      .NB_BYTE(8),
      .N_BYTES(16),
      .N_SBOX(SB[g]),
      .CREATE_OUTPUT_REG(CR[g])
    ) u_dut (
      .i_clock  (clk),
      .i_reset  (rst),
      .i_state  (st),
      .i_valid  (vld),
      .i_inverse(inv),
      .o_ready  (w_rdy[g]),
      .o_state  (w_st[g]),
      .o_valid  (w_ov[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (w_ov[i] === 1'b1) begin
        if (vcnt[i] < LOGN) begin
          vlog[i][vcnt[i]] <= w_st[i];
          vcyc[i][vcnt[i]] <= cyc;
        end
        vcnt[i] <= vcnt[i] + 1;
        if (prev_ov[i]) consec[i] <= consec[i] + 1;
      end
      prev_ov[i] <= (w_ov[i] === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "time limit");
  end

  function automatic int pp(input int i);
    return 16 / SB[i];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Table built by walking generator 3 and its inverse, independent of any field inversion.
  task automatic build_model();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      fsb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    fsb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[fsb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] s, input logic m);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[b*8 +: 8] = m ? isb[s[b*8 +: 8]] : fsb[s[b*8 +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [127:0] obs,
                     input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, expv);
    end
  endtask

  task automatic chk_i(input string tag, input int idx, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, expv);
    end
  endtask

  // Single request on all instances; inputs are scrambled right after the accept edge.
  task automatic run_one(input string tag, input logic [127:0] s, input logic m,
                         input logic [127:0] expv);
    int rc;
    int base [ND];
    base = vcnt;
    st   = s;
    inv  = m;
    vld  = 1'b1;
    rc   = cyc;
    @(negedge clk);
    vld = 1'b0;
    st  = ~s;
    inv = ~m;
    repeat (24) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk_i({tag, "_count"}, i, vcnt[i] - base[i], 1);
      if (base[i] < LOGN) begin
        chk(tag, i, vlog[i][base[i]], expv);
        chk_i({tag, "_lat"}, i, vcyc[i][base[i]] - rc, pp(i) + 1 + CR[i]);
      end
    end
  endtask

  initial begin
    logic [127:0] dv [15];
    logic [127:0] rs;
    logic         rm;
    int           rc;
    int           rc0;
    int           ne;
    int           k;
    int           base [ND];

    build_model();

    rst = 1'b1;
    vld = 1'b1;
    inv = 1'b0;
    st  = '1;
    repeat (3) begin
      @(negedge clk);
      st = ~st;
      for (int i = 0; i < ND; i++) begin
        chk_i("rst_valid", i, int'(w_ov[i]), 0);
        chk_i("rst_ready", i, int'(w_rdy[i]), 0);
        chk("rst_state", i, w_st[i], 128'd0);
      end
    end
    rst = 1'b0;
    vld = 1'b0;
    st  = '0;
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk_i("release_ready", i, int'(w_rdy[i]), 1);
      chk_i("release_valid", i, int'(w_ov[i]), 0);
    end

    run_one("fwd_zero", 128'd0, 1'b0, {16{8'h63}});
    run_one("fwd_53_01", 128'h0153, 1'b0, {{14{8'h63}}, 8'h7C, 8'hED});
    run_one("inv_roundtrip", {{14{8'h63}}, 8'h7C, 8'hED}, 1'b1, 128'h0153);
    run_one("inv_63", {16{8'h63}}, 1'b1, 128'd0);

    // Continuous i_valid: only requests seen while o_ready is high are taken.
    for (int j = 0; j < 15; j++) dv[j] = {$urandom, $urandom, $urandom, $urandom};
    base = vcnt;
    rc0  = cyc;
    for (int j = 0; j < 15; j++) begin
      for (int i = 0; i < ND; i++)
        chk_i("drop_ready", i, int'(w_rdy[i]), ((j % (pp(i) + 1)) == 0) ? 1 : 0);
      st  = dv[j];
      inv = j[0];
      vld = 1'b1;
      @(negedge clk);
    end
    vld = 1'b0;
    repeat (24) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      ne = 14 / (pp(i) + 1) + 1;
      chk_i("drop_count", i, vcnt[i] - base[i], ne);
      for (int j = 0; j < ne; j++) begin
        k = j * (pp(i) + 1);
        if (base[i] + j < LOGN) begin
          chk("drop_state", i, vlog[i][base[i] + j], ref_sub(dv[k], k[0]));
          chk_i("drop_lat", i, vcyc[i][base[i] + j] - (rc0 + k), pp(i) + 1 + CR[i]);
        end
      end
    end

    // Reset lands on the edge where the P=4 instances would write slice 2.
    base = vcnt;
    st   = 128'h00112233445566778899AABBCCDDEEFF;
    inv  = 1'b0;
    vld  = 1'b1;
    rc   = cyc;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk_i("midrst_ready", i, int'(w_rdy[i]), 0);
      chk_i("midrst_valid", i, int'(w_ov[i]), 0);
      chk("midrst_state", i, w_st[i], 128'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < ND; i++) chk_i("midrst_rel_ready", i, int'(w_rdy[i]), 1);
    repeat (24) @(negedge clk);
    for (int i = 0; i < ND; i++)
      chk_i("midrst_count", i, vcnt[i] - base[i], (pp(i) + CR[i] <= 2) ? 1 : 0);
    run_one("post_rst", 128'h0153, 1'b0, {{14{8'h63}}, 8'h7C, 8'hED});

    repeat (4) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rm = 1'($urandom_range(0, 1));
      run_one("sweep", rs, rm, ref_sub(rs, rm));
    end

    for (int i = 0; i < ND; i++) chk_i("consecutive_valid", i, consec[i], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
